// File: rtl/am2910_sequencer.sv
// Am2910-style microprogram sequencer: next-address mux, uPC, loop register R
// and a shallow subroutine/loop stack, plus D-source enables for the branch bus.
module am2910_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        I,
    input  logic [ADDR_W-1:0] D,
    input  logic              COND,
    input  logic              CCEN,
    input  logic              RLD_N,
    input  logic              CI,
    output logic [ADDR_W-1:0] Y,
    output logic              FULL,
    output logic              PL_EN,
    output logic              MAP_EN,
    output logic              VECT_EN
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [3:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } instr_e;

    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [SP_W-1:0]   sp_q;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              pass;
    logic              r0;
    logic [ADDR_W-1:0] tos;
    logic              do_push, do_pop, do_clr, do_rld, do_rdec;
    instr_e            instr;

    assign instr = instr_e'(I);
    assign pass  = ~CCEN | COND;
    assign r0    = (r_q == '0);
    assign FULL  = (sp_q == SP_W'(STACK_DEPTH));

    // An empty stack reads as zero rather than a stale entry.
    always_comb begin
        tos = '0;
        for (int k = 0; k < STACK_DEPTH; k++) begin
            if (sp_q == SP_W'(k + 1)) tos = stack_q[k];
        end
    end

    always_comb begin
        Y        = upc_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_clr   = 1'b0;
        do_rld   = 1'b0;
        do_rdec  = 1'b0;
        unique case (instr)
            JZ: begin
                Y      = '0;
                do_clr = 1'b1;
            end
            CJS: begin
                if (pass) begin
                    Y       = D;
                    do_push = 1'b1;
                end
            end
            JMAP: Y = D;
            CJP:  if (pass) Y = D;
            PUSH: begin
                do_push = 1'b1;
                do_rld  = pass;
            end
            JSRP: begin
                Y       = pass ? D : r_q;
                do_push = 1'b1;
            end
            CJV:  if (pass) Y = D;
            JRP:  Y = pass ? D : r_q;
            RFCT: begin
                if (!r0) begin
                    Y       = tos;
                    do_rdec = 1'b1;
                end else begin
                    do_pop = 1'b1;
                end
            end
            RPCT: begin
                if (!r0) begin
                    Y       = D;
                    do_rdec = 1'b1;
                end
            end
            CRTN: begin
                if (pass) begin
                    Y      = tos;
                    do_pop = 1'b1;
                end
            end
            CJPP: begin
                if (pass) begin
                    Y      = D;
                    do_pop = 1'b1;
                end
            end
            LDCT: do_rld = 1'b1;
            LOOP: begin
                if (pass) do_pop = 1'b1;
                else      Y      = tos;
            end
            CONT: Y = upc_q;
            TWB: begin
                if (pass) begin
                    do_pop = 1'b1;
                end else if (!r0) begin
                    Y       = tos;
                    do_rdec = 1'b1;
                end else begin
                    Y      = D;
                    do_pop = 1'b1;
                end
            end
            default: Y = upc_q;
        endcase
    end

    assign PL_EN   = (instr != JMAP) && (instr != CJV);
    assign MAP_EN  = (instr == JMAP);
    assign VECT_EN = (instr == CJV);

    assign upc_d = Y + {{(ADDR_W-1){1'b0}}, CI};

    // External load outranks any instruction effect on R.
    always_comb begin
        r_d = r_q;
        if (!RLD_N)       r_d = D;
        else if (do_rld)  r_d = D;
        else if (do_rdec) r_d = r_q - 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            upc_q <= '0;
            r_q   <= '0;
            sp_q  <= '0;
            for (int k = 0; k < STACK_DEPTH; k++) stack_q[k] <= '0;
        end else begin
            upc_q <= upc_d;
            r_q   <= r_d;
            if (do_clr) begin
                sp_q <= '0;
            end else if (do_push) begin
                // A push into a full stack overwrites the top slot in place.
                if (FULL) begin
                    stack_q[STACK_DEPTH-1] <= upc_q;
                end else begin
                    for (int k = 0; k < STACK_DEPTH; k++) begin
                        if (sp_q == SP_W'(k)) stack_q[k] <= upc_q;
                    end
                    sp_q <= sp_q + 1'b1;
                end
            end else if (do_pop && (sp_q != '0)) begin
                sp_q <= sp_q - 1'b1;
            end
        end
    end

endmodule

// File: doc/am2910_sequencer.md
# am2910_sequencer

Microprogram sequencer that generates the next microinstruction address for the Am2901 ALU slice datapath. It implements the 16-instruction Am2910-style next-address set: a microprogram counter, a register/counter for loops, and a 5-deep subroutine/loop stack. Its address output drives the microcode store, whose pipeline register supplies the slice's I[8:0], A, B and Cn fields. It also selects which source (pipeline, mapping PROM or vector) supplies the branch address D.

## Interface
- ADDR_W, 12, width of microaddress, D, Y, uPC, R and stack entries
- STACK_DEPTH, 5, number of stack entries
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- I  input  4  next-address instruction (0..15, encoding below)
- D  input  ADDR_W  branch address / counter load value
- COND  input  1  test condition, active-high
- CCEN  input  1  condition enable; when 0 the test always passes
- RLD_N  input  1  active-low; when 0, R loads D this cycle regardless of I
- CI  input  1  incrementer carry-in; uPC <= Y + CI
- Y  output  ADDR_W  next microaddress (combinational)
- FULL  output  1  high when stack holds STACK_DEPTH entries
- PL_EN, MAP_EN, VECT_EN  output  1 each  one-hot D-source enables (MAP_EN for I=2, VECT_EN for I=6, PL_EN otherwise)

## Operation
- PASS = ~CCEN | COND. R0 = (R == 0). TOS = stack[SP-1]. Push writes uPC. Pop decrements SP.
- 0 JZ: Y=0; SP<=0.
- 1 CJS: PASS: Y=D, push. Fail: Y=uPC.
- 2 JMAP: Y=D.
- 3 CJP: PASS: Y=D. Fail: Y=uPC.
- 4 PUSH: Y=uPC; push; if PASS, R<=D.
- 5 JSRP: Y = PASS ? D : R; push.
- 6 CJV: PASS: Y=D. Fail: Y=uPC.
- 7 JRP: Y = PASS ? D : R.
- 8 RFCT: ~R0: Y=TOS, R<=R-1. R0: Y=uPC, pop.
- 9 RPCT: ~R0: Y=D, R<=R-1. R0: Y=uPC.
- 10 CRTN: PASS: Y=TOS, pop. Fail: Y=uPC.
- 11 CJPP: PASS: Y=D, pop. Fail: Y=uPC.
- 12 LDCT: Y=uPC; R<=D.
- 13 LOOP: PASS: Y=uPC, pop. Fail: Y=TOS.
- 14 CONT: Y=uPC.
- 15 TWB: PASS: Y=uPC, pop. Fail with ~R0: Y=TOS, R<=R-1. Fail with R0: Y=D, pop.
- Register R priority: RLD_N=0 load D > instruction load D > instruction decrement > hold. The decrement computes R-1 modulo 2^ADDR_W, but it is only issued when R != 0.
- Stack full: a push while FULL overwrites stack[STACK_DEPTH-1] and SP stays at STACK_DEPTH.
- Stack empty: a pop while SP=0 leaves SP at 0. Reading TOS when empty returns 0.
- PUSH/JSRP with RLD_N=0: both the push and the R load occur.
- uPC wraps: Y = all-ones with CI=1 gives uPC=0.

## Timing
- Y, PL_EN, MAP_EN and VECT_EN are purely combinational from I, COND, CCEN, D, R, uPC and stack.
- uPC, R, SP and stack update on the rising CLK edge. There is a one-cycle latency from the instruction to its state effect.
- RST asserted: immediately uPC=0, R=0, SP=0, all stack entries 0, FULL=0. Y then follows the current I (for I=14, Y=0).
- RST deasserted mid-sequence: the first clock edge after release operates from the reset state. There is no replay of the interrupted instruction.
- FULL is registered-state-derived: FULL = (SP == STACK_DEPTH).

## Test plan
- Reset, then CONT with CI=1 for 4 clocks -> Y = 0, 1, 2, 3; uPC=4; FULL=0.
- At uPC=0x010: CJS D=0x100, COND=1. Next cycle CRTN with COND=1 -> Y=0x100 then Y=0x010; SP returns to 0.
- LDCT D=3, then RPCT D=0x050 for repeated cycles -> Y=0x050 for 3 cycles while R goes 3→2→1→0, then Y=uPC.
- 6 consecutive PUSH -> FULL=1 after 5; the 6th overwrites stack[4]. Then 6 CRTN with CCEN=0 -> pops stop at SP=0 and Y=0 on the empty read.
- TWB with R=2, COND=0 -> Y=TOS and R=1. With R=0, COND=0 -> Y=D and pop. With COND=1 -> Y=uPC and pop.
- Assert RST between a PUSH and the following CRTN -> SP=0, uPC=0, R=0 immediately; the CRTN after release yields Y=0.
